e5_rr_arbiter: RTL and testbench
================================

// Module: e5_rr_arbiter
// PURPOSE
// - 4-requester round-robin arbiter that sequences exclusive access to a shared resource.
// - Grant is registered, one-hot and produced through a 2-to-4 decode of the owner id.
// - Active-low enable gates the decode, the same enable scheme as the 2-to-4 decoder
//   used in the datapath.
// - Sits between up to 4 requesting blocks and the shared unit they contend for.
// PARAMETERS
// - MAX_HOLD  default 8  max consecutive GRANT cycles per tenure; range 2..255.
//                        Used only when ARB_TIMEOUT_EN is defined.
// - CNTW      default 8  width of the hold counter; MAX_HOLD must be < 2**CNTW.
// PORTS
// - clk       in   1  clock; rising edge.
// - rst       in   1  asynchronous reset, active-high.
// - en_n      in   1  active-low enable. While en_n=1: no arbitration, any grant is dropped.
// - req       in   4  request per requester. Holding req high keeps the grant.
// - gnt       out  4  one-hot grant, registered. All zero when no owner.
// - gnt_id    out  2  binary id of the current or last owner.
// - gnt_vld   out  1  1 while some gnt bit is high (OR of gnt).
// - timeout   out  1  1-cycle pulse on a forced release (ARB_TIMEOUT_EN only, else 0).
// BEHAVIOUR
// - Clock and reset: one clock domain, clk. rst is asynchronous and active-high.
// - Reset values: state=IDLE, gnt=0000, gnt_id=00, gnt_vld=0, timeout=0, hold_cnt=0,
//   last_id=11. With last_id=11, the first search starts at requester 0.
// - FSM states: IDLE and GRANT.
// - IDLE: if en_n=0 and req!=0, pick the winner by searching last_id+1, +2, +3, +4 (mod 4)
//   and taking the first set req bit. On the next edge:
//   - state=GRANT
//   - gnt_id=winner and last_id=winner
//   - gnt=decode(winner), hold_cnt=1
// - IDLE with req=0 or en_n=1: stay in IDLE, outputs hold their idle values.
// - Latency: req rising in IDLE gives gnt high on the 1st edge after it is sampled.
// - GRANT: the owner keeps the grant while req[gnt_id]=1 and en_n=0; hold_cnt increments.
// - Release: if req[gnt_id]=0 or en_n=1, go to IDLE on the next edge with gnt=0000.
//   - This gives one mandatory dead cycle between owners; no back-to-back handoff.
// - Requests from non-owners are ignored during GRANT and are not latched.
//   A requester must keep req high to be served.
// - Fairness: after owner k releases, priority restarts at k+1, so every continuously
//   asserted requester is granted within 3 tenures.
// - Simultaneous events: an owner dropping req in the same cycle another raises req
//   causes a release. The new requester is arbitrated in the following IDLE cycle.
// - gnt_id is kept after release (it shows the last owner); gnt_vld=0 shows no owner.
// - Invariants: gnt is always 0000 or one-hot, and gnt_vld == |gnt.
// - Reset mid-tenure: gnt drops asynchronously and the round-robin pointer returns to
//   last_id=11.
// - hold_cnt saturates at 2**CNTW-1 when timeout is compiled out. It is never visible.
// CONFIGURATION
// - Macro ARB_TIMEOUT_EN defined:
//   - In GRANT with hold_cnt==MAX_HOLD and the owner still requesting, force a release.
//   - Next edge: IDLE, gnt=0000, and timeout=1 for exactly one cycle.
//   - The pointer has already advanced, so a different requester (if any) wins next.
//     A lone requester is re-granted after the dead cycle.
// - Macro ARB_TIMEOUT_EN not defined: no forced release, an owner may hold forever,
//   and timeout is tied to 0.
// TESTING
// - Reset: rst=1 then 0, req=0000 -> gnt=0000, gnt_vld=0, gnt_id=00 held for 5 cycles.
// - Single request: req=0100 -> gnt=0100, gnt_id=10 one edge later; req=0000 -> gnt=0000 next edge.
// - Rotation: req=1111 with each owner dropping req after 2 cycles and raising it again
//   -> grant order 0001, 0010, 0100, 1000, 0001, with a dead cycle between each.
// - Enable: en_n=1 with req=0011 -> gnt stays 0000. en_n rising during GRANT ->
//   gnt=0000 next edge, and no re-grant until en_n=0.
// - Timeout (ARB_TIMEOUT_EN, MAX_HOLD=8): req=0011 held -> gnt=0001 for 8 cycles,
//   timeout pulse, then gnt=0010 for 8 cycles, then back to 0001.
// - Async reset mid-GRANT: assert rst between edges while gnt=1000 -> gnt=0000 immediately.
//   After release with req=1001, the winner is 0001.

Source files
------------

// File: rtl/e5_rr_arbiter_if.sv
// Handshake bundle between the requesting blocks and the arbiter.
// master: requester side; slave: arbiter side.
interface e5_rr_arbiter_if;
    logic       en_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    modport master (
        output en_n,
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_vld,
        input  timeout
    );

    modport slave (
        input  en_n,
        input  req,
        output gnt,
        output gnt_id,
        output gnt_vld,
        output timeout
    );
endinterface

// File: rtl/e5_rr_arbiter.sv
// 4-requester round-robin arbiter, registered one-hot grant.
// Optional forced release after MAX_HOLD cycles: define ARB_TIMEOUT_EN.
module e5_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNTW     = 8
) (
    input logic           clk,
    input logic           rst,
    e5_rr_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Reject parameter sets the hold counter cannot represent.
    if (MAX_HOLD < 2 || MAX_HOLD > 255 || MAX_HOLD >= (2 ** CNTW)) begin : g_bad_param
        $error("e5_rr_arbiter: MAX_HOLD out of range for CNTW");
    end

    state_t          state_q, state_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [1:0]      gnt_id_q, gnt_id_d;
    logic [1:0]      last_id_q, last_id_d;
    logic            timeout_q, timeout_d;
    logic [CNTW-1:0] hold_cnt_q, hold_cnt_d;

    logic [1:0]      winner;
    logic [1:0]      cand;
    logic            found;
    logic            owner_req;
    logic            hold_hit;
    logic [CNTW-1:0] hold_inc;

    // 2-to-4 decode gated by the active-low enable, same as the datapath decoder.
    function automatic logic [3:0] dec2to4(input logic [1:0] sel, input logic en_n);
        logic [3:0] y;
        y = 4'b0000;
        if (!en_n) begin
            y[sel] = 1'b1;
        end
        return y;
    endfunction

    // Round-robin search starting just after the last owner.
    always_comb begin
        winner = last_id_q;
        cand   = last_id_q;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_id_q + 2'(k);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Owner status and the saturating tenure counter.
    always_comb begin
        owner_req = bus.req[gnt_id_q];
        hold_inc  = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 1'b1;
`ifdef ARB_TIMEOUT_EN
        hold_hit  = (hold_cnt_q == CNTW'(MAX_HOLD));
`else
        hold_hit  = 1'b0;
`endif
    end

    // Next-state and registered-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        last_id_d  = last_id_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (!bus.en_n && found) begin
                    state_d    = GRANT;
                    gnt_id_d   = winner;
                    last_id_d  = winner;
                    gnt_d      = dec2to4(winner, bus.en_n);
                    hold_cnt_d = CNTW'(1);
                end
            end
            GRANT: begin
                if (!owner_req || bus.en_n) begin
                    state_d    = IDLE;
                    gnt_d      = 4'b0000;
                    hold_cnt_d = '0;
                end else if (hold_hit) begin
                    state_d    = IDLE;
                    gnt_d      = 4'b0000;
                    hold_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_inc;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State register; reset points the search at requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 4'b0000;
            gnt_id_q   <= 2'b00;
            last_id_q  <= 2'b11;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            last_id_q  <= last_id_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.gnt_vld = |gnt_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_e5_rr_arbiter.sv
// Self-checking bench for e5_rr_arbiter: directed literals plus
// randomized traffic against a tenure-level model.
module tb_e5_rr_arbiter;

    localparam int MAXH = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    e5_rr_arbiter_if bus ();

    e5_rr_arbiter #(
        .MAX_HOLD(MAXH),
        .CNTW    (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: current owner (-1 none), last owner, tenure length, pulse.
    int       m_owner;
    int       m_last;
    int       m_id;
    int       m_len;
    bit       m_tmo;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_last  = 3;
            m_id    = 0;
            m_len   = 0;
            m_tmo   = 1'b0;
        end else begin
            m_tmo = 1'b0;
            if (m_owner < 0) begin
                if (!bus.en_n && bus.req != 4'b0000) begin
                    for (int k = 1; k <= 4; k++) begin
                        if (m_owner < 0 && bus.req[(m_last + k) % 4]) begin
                            m_owner = (m_last + k) % 4;
                        end
                    end
                    m_last = m_owner;
                    m_id   = m_owner;
                    m_len  = 1;
                end
            end else if (bus.en_n || !bus.req[m_owner]) begin
                m_owner = -1;
            end else if (TMO && m_len == MAXH) begin
                m_owner = -1;
                m_tmo   = 1'b1;
            end else begin
                m_len++;
            end
        end
    end

    // Compare DUT to the model every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        chk("m_gnt", 32'(bus.gnt), 32'(eg));
        chk("m_gnt_id", 32'(bus.gnt_id), 32'(m_id));
        chk("m_gnt_vld", 32'(bus.gnt_vld), 32'(m_owner >= 0));
        chk("m_timeout", 32'(bus.timeout), 32'(m_tmo));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        bus.req  = 4'b0000;
        bus.en_n = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] r;
        n_chk    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.req  = 4'b0000;
        bus.en_n = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state held with no requests.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_gnt", 32'(bus.gnt), 32'h0);
            chk("rst_id", 32'(bus.gnt_id), 32'h0);
            chk("rst_vld", 32'(bus.gnt_vld), 32'h0);
        end

        // Single request and release.
        bus.req = 4'b0100;
        tick();
        chk("single_gnt", 32'(bus.gnt), 32'h4);
        chk("single_id", 32'(bus.gnt_id), 32'h2);
        bus.req = 4'b0000;
        tick();
        chk("single_rel", 32'(bus.gnt), 32'h0);
        chk("single_id_kept", 32'(bus.gnt_id), 32'h2);

        // Rotation with each owner dropping after two cycles.
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            r = 4'b0001 << (i % 4);
            tick();
            chk("rot_gnt", 32'(bus.gnt), 32'(r));
            tick();
            chk("rot_hold", 32'(bus.gnt), 32'(r));
            bus.req = 4'b1111 & ~r;
            tick();
            chk("rot_dead", 32'(bus.gnt), 32'h0);
            bus.req = 4'b1111;
        end

        // Enable gating.
        do_reset();
        bus.en_n = 1'b1;
        bus.req  = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_block", 32'(bus.gnt), 32'h0);
        end
        bus.en_n = 1'b0;
        tick();
        chk("en_grant", 32'(bus.gnt), 32'h1);
        bus.en_n = 1'b1;
        tick();
        chk("en_drop", 32'(bus.gnt), 32'h0);
        tick();
        chk("en_nogrant", 32'(bus.gnt), 32'h0);
        bus.en_n = 1'b0;
        tick();
        chk("en_regrant", 32'(bus.gnt), 32'h2);

        // Async reset mid-tenure.
        do_reset();
        bus.req = 4'b1000;
        tick();
        chk("ar_gnt", 32'(bus.gnt), 32'h8);
        #1 rst = 1'b1;
        #1 chk("ar_drop", 32'(bus.gnt), 32'h0);
        rst     = 1'b0;
        bus.req = 4'b1001;
        tick();
        chk("ar_winner", 32'(bus.gnt), 32'h1);

        // Long hold: forced release only with the timeout compiled in.
        do_reset();
        bus.req = 4'b0011;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (TMO) begin
                if (i < 8)
                    chk("to_a", 32'(bus.gnt), 32'h1);
                else if (i == 8 || i == 17)
                    chk("to_pulse", 32'({bus.timeout, bus.gnt}), 32'h10);
                else if (i < 17)
                    chk("to_b", 32'(bus.gnt), 32'h2);
                else
                    chk("to_back", 32'(bus.gnt), 32'h1);
            end else begin
                chk("hold_forever", 32'({bus.timeout, bus.gnt}), 32'h1);
            end
        end

        // Randomized traffic against the model.
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            if ($urandom_range(0, 9) == 0) r = r & ~bus.gnt;
            bus.req  = r;
            bus.en_n = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick();
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
